// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
//   Shared constants and types for the CPU register file.
//   - REG_ZERO / REG_SP / REG_RA : architectural register indices ($zero, $sp, $ra)
//   - DATA_W_DEF / ADDR_W_DEF    : default register width and index width
//   - reg_idx_t                  : register index type at the default index width
// -----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

endpackage : reg_file_pkg

// File: rtl/reg_file_rdport.sv
// -----------------------------------------------------------------------------
// reg_file_rdport
//   One combinational read port of the register file. Forces index 0 to read
//   zero and, when REG_FILE_BYPASS_EN is defined, forwards same-cycle write
//   data for a matching index (link write has priority for r31).
// Ports:
//   word      in   DATA_W  array word currently stored at idx
//   idx       in   ADDR_W  read index
//   wr_en     in   1       pending write-back (bypass build only; already
//                          excludes r0 and the link-overridden r31 case)
//   wr_idx    in   ADDR_W  pending write-back index (bypass build only)
//   wr_data   in   DATA_W  pending write-back data (bypass build only)
//   link_en   in   1       pending link write to r31 (bypass build only)
//   link_data in   DATA_W  pending link data (bypass build only)
//   data      out  DATA_W  read result
// Configuration macro: REG_FILE_BYPASS_EN
// -----------------------------------------------------------------------------
module reg_file_rdport
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
`ifdef REG_FILE_BYPASS_EN
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_data,
`endif
  input  logic [DATA_W-1:0] word,
  input  logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] data
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
`ifdef REG_FILE_BYPASS_EN
  localparam logic [ADDR_W-1:0] RA_IDX   = ADDR_W'(REG_RA);
`endif

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    data = word;
`ifdef REG_FILE_BYPASS_EN
    if (link_en && (idx == RA_IDX)) begin
      data = link_data;
    end else if (wr_en && (idx == wr_idx)) begin
      data = wr_data;
    end
`endif
    // r0 is hard-wired to zero regardless of storage or forwarding.
    if (idx == ZERO_IDX) begin
      data = '0;
    end
  end

endmodule : reg_file_rdport

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   32x32 general-purpose register file for the single-cycle CPU. Clocked
//   storage, two combinational read ports (rs, rt), one write-back port and a
//   jal link port that always targets r31. r29 ($sp) resets to SP_INIT.
// Ports:
//   clk_i        in   1       clock, writes on rising edge
//   rst_n        in   1       asynchronous active-low reset
//   rs_addr_i    in   ADDR_W  read port A index
//   rt_addr_i    in   ADDR_W  read port B index
//   rd_addr_i    in   ADDR_W  write-back destination index
//   rd_data_i    in   DATA_W  write-back data
//   reg_write_i  in   1       write-back enable
//   link_i       in   1       link write enable (r31)
//   link_data_i  in   DATA_W  link value (PC+4)
//   rs_data_o    out  DATA_W  read port A data
//   rt_data_o    out  DATA_W  read port B data
// Configuration macro: REG_FILE_BYPASS_EN (same-cycle write-to-read forwarding)
// -----------------------------------------------------------------------------
module reg_file
  import reg_file_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(128)
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              reg_write_i,
  input  logic              link_i,
  input  logic [DATA_W-1:0] link_data_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o
);

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] RA_IDX   = ADDR_W'(REG_RA);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Effective write-back: never r0, and yields r31 to a simultaneous link.
  logic wb_en;
  assign wb_en = reg_write_i && (rd_addr_i != ZERO_IDX) &&
                 !(link_i && (rd_addr_i == RA_IDX));

  // NOTE: the array is reset explicitly because software relies on zeroed
  // registers and a valid $sp straight out of reset; this costs flops, not RAM.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every read this cycle sees pre-edge state.
      if (wb_en) begin
        regs[rd_addr_i] <= rd_data_i;
      end
      if (link_i) begin
        regs[RA_IDX] <= link_data_i;
      end
    end
  end

  reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_port (
`ifdef REG_FILE_BYPASS_EN
    .wr_en     (wb_en),
    .wr_idx    (rd_addr_i),
    .wr_data   (rd_data_i),
    .link_en   (link_i),
    .link_data (link_data_i),
`endif
    .word      (regs[rs_addr_i]),
    .idx       (rs_addr_i),
    .data      (rs_data_o)
  );

  reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_port (
`ifdef REG_FILE_BYPASS_EN
    .wr_en     (wb_en),
    .wr_idx    (rd_addr_i),
    .wr_data   (rd_data_i),
    .link_en   (link_i),
    .link_data (link_data_i),
`endif
    .word      (regs[rt_addr_i]),
    .idx       (rt_addr_i),
    .data      (rt_data_o)
  );

endmodule : reg_file
